// File: rtl/oled_spi_cmd_receiver.sv
// SPI-slave (mode 3) byte receiver and OLED command-frame parser.
// Pin inputs are oversampled on clk. Decoded commands and data bytes are pulsed out one clock after bit 8 is detected.
module oled_spi_cmd_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter bit LOCK_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SPI_CLK,
  input  logic        SPI_MOSI,
  input  logic        SPI_CS,
  input  logic        data_command,
  output logic        cmd_valid,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_args,
  output logic [2:0]  cmd_nargs,
  output logic        data_valid,
  output logic [7:0]  data_byte,
  output logic        display_on,
  output logic        locked,
  output logic        err_unknown,
  output logic        err_frame
);

  typedef enum logic {IDLE, ARGS} state_t;

  // Pin order {dc, cs, mosi, sclk}; clock and chip select idle high.
  localparam logic [3:0] SYNC_RST = 4'b0101;

  logic [3:0]                  pin_raw, pin_s;
  logic [3:0][SYNC_STAGES-1:0] sync_ff;

  assign pin_raw = {data_command, SPI_CS, SPI_MOSI, SPI_CLK};

  for (genvar g = 0; g < 4; g++) begin : g_sync
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_ff[g] <= {SYNC_STAGES{SYNC_RST[g]}};
      else        sync_ff[g] <= {sync_ff[g][SYNC_STAGES-2:0], pin_raw[g]};
    end
    assign pin_s[g] = sync_ff[g][SYNC_STAGES-1];
  end

  logic sclk_s, mosi_s, cs_s, dc_s;
  assign {dc_s, cs_s, mosi_s, sclk_s} = pin_s;

  // ---------------- bit path ----------------
  logic       sclk_prev, cs_prev;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       sclk_rise, cs_rise, cs_err, byte_done;
  logic [7:0] byte_nxt;

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_err    = cs_rise && (bitcnt != 3'd0);
  assign byte_nxt  = {shreg[6:0], mosi_s};
  assign byte_done = sclk_rise && !cs_s && (bitcnt == 3'd7);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_prev <= 1'b1;
      cs_prev   <= 1'b1;
      bitcnt    <= '0;
      shreg     <= '0;
    end else begin
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      if (cs_s) begin
        bitcnt <= '0;
      end else if (sclk_rise) begin
        shreg  <= byte_nxt;
        bitcnt <= bitcnt + 3'd1;
      end
    end
  end

  // ---------------- argument table ----------------
  // Returns {known, need}.
  function automatic logic [3:0] arg_table(input logic [7:0] op);
    case (op)
      8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
      8'h2E, 8'h2F, 8'hE3:                             arg_table = 4'b1_000;
      8'hFD, 8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0,
      8'hB1, 8'hB3, 8'h81, 8'h82, 8'h83, 8'h87, 8'h8A,
      8'h8B, 8'h8C, 8'hBB, 8'hBE:                      arg_table = 4'b1_001;
      8'h25:                                           arg_table = 4'b1_100;
      default:                                         arg_table = 4'b0_000;
    endcase
  endfunction

  // ---------------- parser FSM ----------------
  state_t      state, state_d;
  logic [7:0]  op_q, op_d;
  logic [2:0]  need_q, need_d, nargs_q, nargs_d;
  logic [31:0] args_q, args_d;
  logic [3:0]  tbl;

  assign tbl = arg_table(byte_nxt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      op_q    <= '0;
      need_q  <= '0;
      nargs_q <= '0;
      args_q  <= '0;
    end else begin
      state   <= state_d;
      op_q    <= op_d;
      need_q  <= need_d;
      nargs_q <= nargs_d;
      args_q  <= args_d;
    end
  end

  always_comb begin
    state_d = state;
    op_d    = op_q;
    need_d  = need_q;
    nargs_d = nargs_q;
    args_d  = args_q;
    if (byte_done) begin
      case (state)
        IDLE: if (!dc_s) begin
          op_d    = byte_nxt;
          need_d  = tbl[2:0];
          nargs_d = '0;
          args_d  = '0;
          if (tbl[2:0] != 3'd0) state_d = ARGS;
        end
        ARGS: if (dc_s) begin
          state_d = IDLE;
        end else begin
          args_d  = args_q | ({byte_nxt, 24'h0} >> {nargs_q, 3'b000});
          nargs_d = nargs_q + 3'd1;
          if (nargs_q + 3'd1 == need_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- outputs ----------------
  logic        frame_done, drop, lock_gate;
  logic [7:0]  fin_op;
  logic [31:0] fin_args;
  logic [2:0]  fin_n;
  logic        cmd_valid_d, data_valid_d, err_unknown_d, err_frame_d;
  logic        display_on_d, locked_d;

  assign lock_gate = LOCK_ENABLE && locked;

  always_comb begin
    frame_done    = byte_done && !dc_s &&
                    ((state == IDLE && tbl[2:0] == 3'd0) ||
                     (state == ARGS && nargs_q + 3'd1 == need_q));
    fin_op        = (state == IDLE) ? byte_nxt : op_q;
    fin_args      = (state == IDLE) ? '0 : args_d;
    fin_n         = (state == IDLE) ? 3'd0 : nargs_d;
    // While locked, non-FD frames are parsed (args consumed) but go nowhere.
    drop          = lock_gate && (fin_op != 8'hFD);
    cmd_valid_d   = frame_done && !drop;
    err_unknown_d = cmd_valid_d && (state == IDLE) && !tbl[3];
    data_valid_d  = byte_done && dc_s && (state == IDLE) && !lock_gate;
    err_frame_d   = cs_err || (byte_done && dc_s && state == ARGS);
    display_on_d  = display_on;
    locked_d      = locked;
    if (cmd_valid_d) begin
      if (fin_op == 8'hAF) display_on_d = 1'b1;
      if (fin_op == 8'hAE) display_on_d = 1'b0;
      if (fin_op == 8'hFD && fin_args[31:24] == 8'h16) locked_d = 1'b1;
      if (fin_op == 8'hFD && fin_args[31:24] == 8'h12) locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_valid   <= 1'b0;
      cmd_opcode  <= '0;
      cmd_args    <= '0;
      cmd_nargs   <= '0;
      data_valid  <= 1'b0;
      data_byte   <= '0;
      display_on  <= 1'b0;
      locked      <= 1'b0;
      err_unknown <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      cmd_valid   <= cmd_valid_d;
      data_valid  <= data_valid_d;
      err_unknown <= err_unknown_d;
      err_frame   <= err_frame_d;
      display_on  <= display_on_d;
      locked      <= locked_d;
      if (cmd_valid_d) begin
        cmd_opcode <= fin_op;
        cmd_args   <= fin_args;
        cmd_nargs  <= fin_n;
      end
      if (data_valid_d) data_byte <= byte_nxt;
    end
  end

endmodule
